// File: rtl/regfile_16_pkg.sv
// regfile_16_pkg: shared widths and defaults for the 16-entry register file
package regfile_16_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int ADDR_W       = 4;
  localparam bit ZERO_REG_DEF = 1'b1;
endpackage

// File: rtl/register_32.sv
// register_32: DATA_W-bit D flip-flop with enable and asynchronous active-low clear
module register_32
  import regfile_16_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_q <= '0;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/regfile_16.sv
// regfile_16: 16-entry register file, one write port, two registered read ports with write bypass
module regfile_16
  import regfile_16_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en_a,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic              i_rd_en_b,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_rd_valid_a,
  output logic              o_rd_valid_b
);
  logic [DATA_W-1:0]   w_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_we;
  logic                w_wr_ok;
  logic [DATA_W-1:0]   w_nxt_a, w_nxt_b;
  logic                r_valid_a, r_valid_b;
  // register 0 is never enabled when hardwired, so it stays at its reset value of zero
  assign w_wr_ok = i_wr_en && !(ZERO_REG && i_wr_addr == '0);
  assign w_we    = w_wr_ok ? NUM_REGS'(1) << i_wr_addr : '0;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    register_32 #(.W(DATA_W)) u_reg (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (w_we[g]),
      .i_d    (i_wr_data),
      .o_q    (w_regs[g])
    );
  end
  assign w_nxt_a = (w_wr_ok && i_rd_addr_a == i_wr_addr) ? i_wr_data : w_regs[i_rd_addr_a];
  assign w_nxt_b = (w_wr_ok && i_rd_addr_b == i_wr_addr) ? i_wr_data : w_regs[i_rd_addr_b];
  register_32 #(.W(DATA_W)) u_rd_a (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_rd_en_a),
    .i_d    (w_nxt_a),
    .o_q    (o_rd_data_a)
  );
  register_32 #(.W(DATA_W)) u_rd_b (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_rd_en_b),
    .i_d    (w_nxt_b),
    .o_q    (o_rd_data_b)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= i_rd_en_a;
      r_valid_b <= i_rd_en_b;
    end
  assign o_rd_valid_a = r_valid_a;
  assign o_rd_valid_b = r_valid_b;
endmodule

// File: tb/tb_regfile_16.sv
// tb_regfile_16: randomized and directed checks of regfile_16 against an array model
module tb_regfile_16;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [31:0] wr_data = '0, rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [31:0] mdl [16];
  logic [31:0] exp_a = '0, exp_b = '0;
  logic        exp_va = 1'b0, exp_vb = 1'b0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  regfile_16 dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rd_en_a   (rd_en_a),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_en_b   (rd_en_b),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b),
    .o_rd_valid_a(rd_valid_a),
    .o_rd_valid_b(rd_valid_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_data_a"}, rd_data_a, exp_a);
    chk({tag, "_data_b"}, rd_data_b, exp_b);
    chk({tag, "_valid_a"}, 32'(rd_valid_a), 32'(exp_va));
    chk({tag, "_valid_b"}, 32'(rd_valid_b), 32'(exp_vb));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  // entered at a falling edge, returns at the next falling edge
  task automatic cyc(input string tag, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic ea, input logic [3:0] aa, input logic eb, input logic [3:0] ab);
    logic wr_live;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    @(posedge clk);
    wr_live = we && wa != 4'd0;
    if (ea) exp_a = (wr_live && wa == aa) ? wd : mdl[aa];
    if (eb) exp_b = (wr_live && wa == ab) ? wd : mdl[ab];
    exp_va = ea; exp_vb = eb;
    if (wr_live) mdl[wa] = wd;
    #1 chk_all(tag);
    @(negedge clk);
  endtask

  initial begin
    clear_model();
    #2 rst_n = 1'b0;
    #1 chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("first_read", 0, 0, 0, 1, 4'd5, 1, 4'd15);
    cyc("wr_r3", 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc("rd_r3", 0, 0, 0, 1, 4'd3, 0, 0);
    cyc("idle_hold", 0, 0, 0, 0, 0, 0, 0);
    cyc("wr_r0", 1, 4'd0, 32'h12345678, 0, 0, 0, 0);
    cyc("rd_r0", 0, 0, 0, 1, 4'd0, 1, 4'd0);
    cyc("wr_r0_byp", 1, 4'd0, 32'h55555555, 1, 4'd0, 1, 4'd0);
    cyc("bypass_r7", 1, 4'd7, 32'hCAFEF00D, 1, 4'd7, 1, 4'd7);
    for (int i = 1; i < 16; i++) cyc("fill", 1, 4'(i), 32'(i), 0, 0, 0, 0);
    for (int i = 1; i < 16; i++) cyc("sweep", 0, 0, 0, 1, 4'(i), 1, 4'(16 - i));
    for (int n = 0; n < 400; n++)
      cyc("rand", 1'($urandom), 4'($urandom), $urandom, ($urandom_range(3) != 0), 4'($urandom),
          ($urandom_range(3) != 0), 4'($urandom));
    cyc("wr_r9", 1, 4'd9, 32'hA5A5A5A5, 0, 0, 0, 0);
    cyc("rd_r9", 0, 0, 0, 1, 4'd9, 1, 4'd9);
    rd_en_a = 1'b1; rd_addr_a = 4'd9; rd_en_b = 1'b0; wr_en = 1'b0;
    #2 rst_n = 1'b0;
    clear_model();
    #1 chk_all("async_clear");
    @(posedge clk);
    #1 chk_all("reset_drop");
    rd_en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset_r9", 0, 0, 0, 1, 4'd9, 1, 4'd3);
    cyc("post_reset_wr", 1, 4'd9, 32'h0BADF00D, 1, 4'd9, 0, 0);
    cyc("post_reset_rd", 0, 0, 0, 1, 4'd9, 1, 4'd9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
